// File: rtl/fpu_sequencer.sv
// fpu_sequencer: fetches instructions, reads two operands, runs the FP unit and writes the result back until halt
module fpu_sequencer #(
  parameter int IADDR_W = 5,
  parameter int DADDR_W = 5,
  parameter int EXEC_CYCLES = 1,
  parameter int INSTR_W = 3 + 3 * DADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [DADDR_W-1:0] dmem_raddr,
  input  logic [63:0]        dmem_rdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_waddr,
  output logic [63:0]        dmem_wdata,
  output logic               fpu_enable,
  output logic [63:0]        fpu_a,
  output logic [63:0]        fpu_b,
  output logic [1:0]         fpu_op,
  input  logic [63:0]        fpu_c,
  output logic [15:0]        retired
);
  localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, RDA, RDB, CAPB, EXEC, WB, DONE} state_t;
  state_t state;
  logic [IADDR_W-1:0] pc;
  logic [INSTR_W-1:0] instr;
  logic [63:0] result;
  logic [CW-1:0] cnt;
  logic [DADDR_W-1:0] dst, src_a, src_b;
  assign dst = instr[3*DADDR_W-1 -: DADDR_W];
  assign src_a = instr[2*DADDR_W-1 -: DADDR_W];
  assign src_b = instr[DADDR_W-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign imem_addr = pc;
  assign dmem_raddr = state == RDA ? src_a : state == RDB ? src_b : '0;
  assign dmem_we = state == WB;
  assign dmem_waddr = dst;
  assign dmem_wdata = result;
  assign fpu_enable = state == EXEC;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      instr <= '0;
      fpu_a <= '0;
      fpu_b <= '0;
      fpu_op <= '0;
      result <= '0;
      cnt <= '0;
      retired <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          pc <= '0;
          retired <= '0;
          state <= FETCH;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          instr <= imem_rdata;
          state <= imem_rdata[INSTR_W-1] ? DONE : RDA;
        end
        RDA: state <= RDB;
        RDB: begin
          fpu_a <= dmem_rdata;
          state <= CAPB;
        end
        CAPB: begin
          fpu_b <= dmem_rdata;
          fpu_op <= instr[INSTR_W-2 -: 2];
          cnt <= CW'(EXEC_CYCLES - 1);
          state <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          result <= fpu_c;
          state <= WB;
        end else cnt <= cnt - 1'b1;
        WB: begin
          pc <= pc + 1'b1;
          retired <= retired + 1'b1;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: random and directed programs on two sequencers (EXEC_CYCLES 1 and 4) against an interpreter model
module tb_fpu_sequencer;
  logic clk = 0, rst_n = 0, start = 0, load = 0;
  always #5 clk = ~clk;
  logic busy[2], done[2], we[2], en[2];
  logic [4:0] ia[2], ra[2], wa[2];
  logic [17:0] ir[2];
  logic [63:0] dr[2], wd[2], fa[2], fb[2], fc[2];
  logic [1:0] op[2];
  logic [15:0] ret[2];
  logic [17:0] imem[32];
  logic [63:0] dm[2][32];
  logic [63:0] dinit[32];
  int errs = 0, checks = 0;

  fpu_sequencer #(.EXEC_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]),
    .done(done[0]), .imem_addr(ia[0]), .imem_rdata(ir[0]), .dmem_raddr(ra[0]), .dmem_rdata(dr[0]),
    .dmem_we(we[0]), .dmem_waddr(wa[0]), .dmem_wdata(wd[0]), .fpu_enable(en[0]), .fpu_a(fa[0]),
    .fpu_b(fb[0]), .fpu_op(op[0]), .fpu_c(fc[0]), .retired(ret[0]));
  fpu_sequencer #(.EXEC_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]),
    .done(done[1]), .imem_addr(ia[1]), .imem_rdata(ir[1]), .dmem_raddr(ra[1]), .dmem_rdata(dr[1]),
    .dmem_we(we[1]), .dmem_waddr(wa[1]), .dmem_wdata(wd[1]), .fpu_enable(en[1]), .fpu_a(fa[1]),
    .fpu_b(fb[1]), .fpu_op(op[1]), .fpu_c(fc[1]), .retired(ret[1]));

  function automatic logic [63:0] fp(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    real x, y;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    case (o)
      2'd0: return $realtobits(x + y);
      2'd1: return $realtobits(x - y);
      2'd2: return $realtobits(x * y);
      default: return $realtobits(x / y);
    endcase
  endfunction

  function automatic logic [17:0] mk(input logic h, input logic [1:0] o, input logic [4:0] d,
                                     input logic [4:0] a, input logic [4:0] b);
    return {h, o, d, a, b};
  endfunction

  assign fc[0] = fp(op[0], fa[0], fb[0]);
  assign fc[1] = fp(op[1], fa[1], fb[1]);

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      ir[i] <= imem[ia[i]];
      dr[i] <= dm[i][ra[i]];
      if (load) dm[i] <= dinit;
      else if (we[i]) dm[i][wa[i]] <= wd[i];
    end

  typedef struct {int i; logic [4:0] a; logic [63:0] d; int t; int en; logic [1:0] o;} wr_t;
  wr_t wq[$];
  int ec = 0;
  int run_len[2] = '{0, 0};
  int dn[2] = '{0, 0};
  int dt[2] = '{0, 0};
  logic [1:0] lop[2];

  // Write log: every committed write with its edge index, EXEC length and op seen while enabled
  always @(posedge clk) begin
    ec++;
    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        run_len[i]++;
        lop[i] = op[i];
      end
      if (we[i]) begin
        wq.push_back('{i, wa[i], wd[i], ec, run_len[i], lop[i]});
        run_len[i] = 0;
      end
      if (!rst_n) run_len[i] = 0;
      if (done[i]) begin
        dn[i]++;
        dt[i] = ec;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rnd_prog(input int n);
    for (int a = 0; a < 32; a++) dinit[a] = $realtobits(real'($urandom_range(1, 64)) / 8.0);
    for (int k = 0; k < 32; k++)
      imem[k] = mk(1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    if (n < 32) imem[n] = mk(1'b1, 2'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic load_dm();
    @(negedge clk) load = 1;
    @(negedge clk) load = 0;
  endtask

  task automatic run(input int n, input bit wrap);
    logic [63:0] m[32];
    logic [17:0] s;
    wr_t ex[$];
    int t0, b, k, e;
    int d0[2];
    m = dinit;
    for (int j = 0; j < n; j++) begin
      s = imem[j];
      ex.push_back('{0, s[14:10], fp(s[16:15], m[s[9:5]], m[s[4:0]]), j, 0, s[16:15]});
      m[s[14:10]] = ex[j].d;
    end
    load_dm();
    b = wq.size();
    d0 = dn;
    start = 1;
    t0 = ec + 1;
    repeat (2) @(negedge clk);
    start = 0;
    if (wrap) begin
      repeat (2) @(negedge clk);
      imem[0] = mk(1'b1, 2'd0, 5'd0, 5'd0, 5'd0);
    end
    for (int c = 0; c < n * 10 + 40 && !(dn[0] > d0[0] && dn[1] > d0[1]); c++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = i ? 4 : 1;
      chk("done_count", 64'(dn[i] - d0[i]), 64'd1);
      chk("done_time", 64'(dt[i]), 64'(t0 + n * (6 + e) + 3));
      chk("retired", 64'(ret[i]), 64'(n));
      chk("busy_after", 64'(busy[i]), 64'd0);
      k = 0;
      for (int j = b; j < wq.size(); j++)
        if (wq[j].i == i) begin
          if (k < n) begin
            chk("wr_addr", 64'(wq[j].a), 64'(ex[k].a));
            chk("wr_data", wq[j].d, ex[k].d);
            chk("wr_time", 64'(wq[j].t), 64'(t0 + (k + 1) * (6 + e)));
            chk("exec_len", 64'(wq[j].en), 64'(e));
            chk("exec_op", 64'(wq[j].o), 64'(ex[k].o));
          end
          k++;
        end
      chk("wr_count", 64'(k), 64'(n));
      for (int a = 0; a < 32; a++) chk("dmem_final", dm[i][a], m[a]);
    end
  endtask

  initial begin
    int b;
    rst_n = 0;
    start = 1;
    for (int a = 0; a < 32; a++) begin
      dinit[a] = '0;
      imem[a] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_done", 64'(done[i]), 64'd0);
      chk("rst_we", 64'(we[i]), 64'd0);
      chk("rst_en", 64'(en[i]), 64'd0);
      chk("rst_retired", 64'(ret[i]), 64'd0);
      chk("rst_fpu_a", fa[i], 64'd0);
      chk("rst_op", 64'(op[i]), 64'd0);
    end
    rst_n = 1;
    start = 0;
    // add 3,1,2
    dinit[1] = 64'h3FF0000000000000;
    dinit[2] = 64'h4000000000000000;
    imem[0] = mk(1'b0, 2'd0, 5'd3, 5'd1, 5'd2);
    imem[1] = mk(1'b1, 2'd0, 5'd0, 5'd0, 5'd0);
    run(1, 1'b0);
    chk("add_e1", dm[0][3], 64'h4008000000000000);
    chk("add_e4", dm[1][3], 64'h4008000000000000);
    // sub/mul/div chain
    dinit[3] = 64'h4008000000000000;
    imem[0] = mk(1'b0, 2'd1, 5'd4, 5'd3, 5'd1);
    imem[1] = mk(1'b0, 2'd2, 5'd5, 5'd2, 5'd3);
    imem[2] = mk(1'b0, 2'd3, 5'd6, 5'd5, 5'd2);
    imem[3] = mk(1'b1, 2'd0, 5'd0, 5'd0, 5'd0);
    run(3, 1'b0);
    chk("sub", dm[0][4], 64'h4000000000000000);
    chk("mul", dm[0][5], 64'h4018000000000000);
    chk("div", dm[1][6], 64'h4008000000000000);
    // in-place add 1,1,1
    imem[0] = mk(1'b0, 2'd0, 5'd1, 5'd1, 5'd1);
    imem[1] = mk(1'b1, 2'd0, 5'd0, 5'd0, 5'd0);
    run(1, 1'b0);
    chk("inplace", dm[0][1], 64'h4000000000000000);
    repeat (6) begin
      int n;
      n = $urandom_range(1, 6);
      rnd_prog(n);
      run(n, 1'b0);
    end
    // pc wraps past 31 and meets a halt planted at 0 after the first fetch
    rnd_prog(32);
    run(32, 1'b1);
    // reset during EXEC aborts without a write, then a fresh start reruns from pc 0
    rnd_prog(3);
    load_dm();
    start = 1;
    @(negedge clk) start = 0;
    for (int c = 0; c < 40 && !en[0]; c++) @(negedge clk);
    chk("exec_reached", 64'(en[0]), 64'd1);
    rst_n = 0;
    b = wq.size();
    repeat (8) @(negedge clk);
    chk("no_wr_after_rst", 64'(wq.size() - b), 64'd0);
    chk("rst_busy_e1", 64'(busy[0]), 64'd0);
    chk("rst_busy_e4", 64'(busy[1]), 64'd0);
    rst_n = 1;
    run(3, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
